// File: rtl/multdiv_issue.sv
// Pipeline-side issue/wait/writeback sequencer for the multdiv unit.
// Optional macro MULTDIV_DIV0_BYPASS_EN: divide-by-zero completes directly from IDLE.
module multdiv_issue #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 48,
   parameter int CNT_W   = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [4:0]       req_rd,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] md_operandA,
   output logic [WIDTH-1:0] md_operandB,
   output logic             md_ctrl_MULT,
   output logic             md_ctrl_DIV,
   input  logic [WIDTH-1:0] md_result,
   input  logic             md_exception,
   input  logic             md_resultRDY,
   output logic             wb_valid,
   output logic [WIDTH-1:0] wb_result,
   output logic             wb_exception,
   output logic [4:0]       wb_rd
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic [WIDTH-1:0] wb_result_q, wb_result_d;
   logic             wb_exception_q, wb_exception_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic             accept;
   logic [CNT_W-1:0] wd_inc;

   assign accept = (state_q == S_IDLE) && req_valid && !flush;
   assign wd_inc = wd_q + CNT_W'(1);

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      rd_d           = rd_q;
      opa_d          = opa_q;
      opb_d          = opb_q;
      wd_d           = wd_q;
      wb_result_d    = wb_result_q;
      wb_exception_d = wb_exception_q;
      wb_rd_d        = wb_rd_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = req_op;
               rd_d    = req_rd;
               opa_d   = req_a;
               opb_d   = req_b;
               state_d = S_START;
`ifdef MULTDIV_DIV0_BYPASS_EN
               if (req_op && (req_b == '0)) begin
                  state_d        = S_DONE;
                  wb_result_d    = '0;
                  wb_exception_d = 1'b1;
                  wb_rd_d        = req_rd;
               end
`else
`endif
            end
         end
         // Ready is ignored here: it may still be asserted from the previous op.
         S_START: begin
            wd_d    = '0;
            state_d = flush ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               wd_d = wd_inc;
               if (md_resultRDY) begin
                  wb_result_d    = md_result;
                  wb_exception_d = md_exception;
                  wb_rd_d        = rd_q;
                  state_d        = S_DONE;
               end else if (wd_inc == TIMEOUT_CNT) begin
                  wb_result_d    = '0;
                  wb_exception_d = 1'b1;
                  wb_rd_d        = rd_q;
                  state_d        = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         op_q           <= 1'b0;
         rd_q           <= '0;
         opa_q          <= '0;
         opb_q          <= '0;
         wd_q           <= '0;
         wb_result_q    <= '0;
         wb_exception_q <= 1'b0;
         wb_rd_q        <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         rd_q           <= rd_d;
         opa_q          <= opa_d;
         opb_q          <= opb_d;
         wd_q           <= wd_d;
         wb_result_q    <= wb_result_d;
         wb_exception_q <= wb_exception_d;
         wb_rd_q        <= wb_rd_d;
      end
   end

   // Stall drops in DONE so the instruction leaves execute as writeback fires.
   assign stall        = accept || (state_q == S_START) || (state_q == S_WAIT);
   assign busy         = (state_q == S_START) || (state_q == S_WAIT);
   assign md_ctrl_MULT = (state_q == S_START) && !op_q;
   assign md_ctrl_DIV  = (state_q == S_START) && op_q;
   assign md_operandA  = opa_q;
   assign md_operandB  = opb_q;
   assign wb_valid     = (state_q == S_DONE) && !flush;
   assign wb_result    = wb_result_q;
   assign wb_exception = wb_exception_q;
   assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the multdiv unit is modelled by driving ready per cycle.
module tb_multdiv_issue;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         req_valid, req_op, flush;
   logic [W-1:0] req_a, req_b;
   logic [4:0]   req_rd;
   logic         stall, busy, md_ctrl_MULT, md_ctrl_DIV;
   logic [W-1:0] md_operandA, md_operandB, md_result;
   logic         md_exception, md_resultRDY;
   logic         wb_valid, wb_exception;
   logic [W-1:0] wb_result;
   logic [4:0]   wb_rd;

   int checks   = 0;
   int failures = 0;

   multdiv_issue dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .flush(flush), .stall(stall), .busy(busy),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .wb_valid(wb_valid), .wb_result(wb_result), .wb_exception(wb_exception), .wb_rd(wb_rd)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         req_valid = 1'b0; flush = 1'b0; md_resultRDY = 1'b0;
         @(negedge clock);
      end
   endtask

   // Cycle 0 is the acceptance cycle; rdy_cyc/flush_cyc are offsets from it (-1 = never).
   task automatic run_op(
      input  logic op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
      input  int rdy_cyc, input logic [W-1:0] res, input logic exc,
      input  int flush_cyc, input logic stale, input int max_cyc,
      output int n_mult, output int n_div, output int first_pulse, output int wb_cyc,
      output logic [W-1:0] wb_res, output logic wb_exc, output logic [4:0] wb_rd_o,
      output int stall_low, output int busy_cnt, output int opnd_bad, output logic [W-1:0] res_mid);
      n_mult = 0; n_div = 0; first_pulse = -1; wb_cyc = -1; wb_res = '0; wb_exc = 1'b0;
      wb_rd_o = '0; stall_low = -1; busy_cnt = 0; opnd_bad = 0; res_mid = '0;
      for (int c = 0; c < max_cyc; c++) begin
         step();
         req_valid = (c == 0); req_op = op; req_a = a; req_b = b; req_rd = rd;
         flush = (c == flush_cyc);
         if (c == rdy_cyc) begin
            md_resultRDY = 1'b1; md_result = res; md_exception = exc;
         end else if (stale && c <= 1) begin
            md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
         end else begin
            md_resultRDY = 1'b0; md_result = 32'h5A5A_5A5A; md_exception = 1'b0;
         end
         @(negedge clock);
         if (md_ctrl_MULT) begin n_mult++; if (first_pulse < 0) first_pulse = c; end
         if (md_ctrl_DIV) begin n_div++; if (first_pulse < 0) first_pulse = c; end
         if (!stall && stall_low < 0) stall_low = c;
         if (busy) busy_cnt++;
         if (c >= 1 && (md_operandA !== a || md_operandB !== b)) opnd_bad++;
         if (c == 3) res_mid = wb_result;
         if (wb_valid) begin
            wb_cyc = c; wb_res = wb_result; wb_exc = wb_exception; wb_rd_o = wb_rd;
            break;
         end
      end
   endtask

   int nm, nd, fp, wc, sl, bc, ob;
   logic [W-1:0] wr, rm;
   logic we;
   logic [4:0] wrd;

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
      flush = 1'b0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
      idle_cycles(3);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b exp=00", {md_ctrl_MULT, md_ctrl_DIV}); end
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      checks++; if ({md_operandA, md_operandB} !== '0) begin failures++; $display("FAIL reset_operands got=%h_%h exp=0", md_operandA, md_operandB); end
      checks++; if ({wb_result, wb_exception, wb_rd} !== '0) begin failures++; $display("FAIL reset_wb got=%h/%b/%0d exp=0/0/0", wb_result, wb_exception, wb_rd); end
      step(); reset = 1'b0; @(negedge clock);
   endtask

   task automatic test_mult();
      run_op(1'b0, 32'd7, 32'd6, 5'd5, 33, 32'd42, 1'b0, -1, 1'b0, 60,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (nm !== 1) begin failures++; $display("FAIL mult_pulse_count got=%0d exp=1", nm); end
      checks++; if (nd !== 0) begin failures++; $display("FAIL mult_div_pulse got=%0d exp=0", nd); end
      checks++; if (fp !== 1) begin failures++; $display("FAIL mult_pulse_cycle got=%0d exp=1", fp); end
      checks++; if (wc !== 34) begin failures++; $display("FAIL mult_wb_cycle got=%0d exp=34", wc); end
      checks++; if (wr !== 32'd42) begin failures++; $display("FAIL mult_result got=%0d exp=42", wr); end
      checks++; if (wrd !== 5'd5) begin failures++; $display("FAIL mult_rd got=%0d exp=5", wrd); end
      checks++; if (we !== 1'b0) begin failures++; $display("FAIL mult_exception got=%b exp=0", we); end
      checks++; if (sl !== 34) begin failures++; $display("FAIL mult_stall_low got=%0d exp=34", sl); end
      checks++; if (bc !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
   endtask

   task automatic test_div();
      run_op(1'b1, 32'd100, 32'd7, 5'd9, 11, 32'd14, 1'b0, -1, 1'b0, 40,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (nd !== 1 || nm !== 0) begin failures++; $display("FAIL div_pulses got=div%0d/mult%0d exp=1/0", nd, nm); end
      checks++; if (wc !== 12) begin failures++; $display("FAIL div_wb_cycle got=%0d exp=12", wc); end
      checks++; if (wr !== 32'd14 || wrd !== 5'd9) begin failures++; $display("FAIL div_result got=%0d/rd%0d exp=14/rd9", wr, wrd); end
      checks++; if (ob !== 0) begin failures++; $display("FAIL div_operand_stable got=%0d exp=0", ob); end
   endtask

   task automatic test_stale_ready();
      run_op(1'b0, 32'd2, 32'd3, 5'd3, 6, 32'd6, 1'b0, -1, 1'b1, 40,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (rm !== 32'd14) begin failures++; $display("FAIL stale_hold got=%h exp=0000000e", rm); end
      checks++; if (wc !== 7) begin failures++; $display("FAIL stale_wb_cycle got=%0d exp=7", wc); end
      checks++; if (wr !== 32'd6 || we !== 1'b0) begin failures++; $display("FAIL stale_result got=%h/%b exp=6/0", wr, we); end
   endtask

   task automatic test_timeout();
      run_op(1'b1, 32'd1, 32'd1, 5'd7, -1, 32'd0, 1'b0, -1, 1'b0, 70,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (wc !== 50) begin failures++; $display("FAIL timeout_wb_cycle got=%0d exp=50", wc); end
      checks++; if (we !== 1'b1 || wr !== '0) begin failures++; $display("FAIL timeout_result got=%h/%b exp=0/1", wr, we); end
   endtask

   task automatic test_flush();
      step(); req_valid = 1'b1; req_op = 1'b0; flush = 1'b1; md_resultRDY = 1'b0;
      @(negedge clock);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
      step(); req_valid = 1'b0; flush = 1'b0;
      @(negedge clock);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
      run_op(1'b0, 32'd11, 32'd13, 5'd4, -1, 32'd0, 1'b0, 12, 1'b0, 13,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (wc !== -1) begin failures++; $display("FAIL flush_wait_wb got=%0d exp=-1", wc); end
      checks++; if (bc !== 12) begin failures++; $display("FAIL flush_wait_busy got=%0d exp=12", bc); end
      run_op(1'b0, 32'd3, 32'd3, 5'd6, 3, 32'd9, 1'b0, -1, 1'b0, 20,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (wc !== 4) begin failures++; $display("FAIL flush_next_wb_cycle got=%0d exp=4", wc); end
      checks++; if (wr !== 32'd9 || wrd !== 5'd6) begin failures++; $display("FAIL flush_next_result got=%0d/rd%0d exp=9/rd6", wr, wrd); end
      run_op(1'b0, 32'd4, 32'd5, 5'd2, 3, 32'd20, 1'b0, 4, 1'b0, 6,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (wc !== -1) begin failures++; $display("FAIL flush_done_wb got=%0d exp=-1", wc); end
      checks++; if (sl !== 4) begin failures++; $display("FAIL flush_done_stall_low got=%0d exp=4", sl); end
   endtask

   task automatic test_reset_mid_op();
      run_op(1'b0, 32'd8, 32'd8, 5'd1, -1, 32'd0, 1'b0, -1, 1'b0, 6,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      step(); reset = 1'b1; @(negedge clock);
      step(); reset = 1'b0; @(negedge clock);
      checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_op got=busy%b/wb%b exp=0/0", busy, wb_valid); end
      checks++; if (md_operandA !== '0 || wb_result !== '0) begin failures++; $display("FAIL reset_mid_op_regs got=%h/%h exp=0/0", md_operandA, wb_result); end
      run_op(1'b0, 32'd2, 32'd2, 5'd10, 3, 32'd4, 1'b0, -1, 1'b0, 10,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
      checks++; if (wc !== 4 || wr !== 32'd4 || wrd !== 5'd10) begin failures++; $display("FAIL reset_rearm got=cyc%0d/%0d/rd%0d exp=cyc4/4/rd10", wc, wr, wrd); end
   endtask

   task automatic test_div_zero();
      run_op(1'b1, 32'd5, 32'd0, 5'd8, 5, 32'd0, 1'b1, -1, 1'b0, 20,
             nm, nd, fp, wc, wr, we, wrd, sl, bc, ob, rm);
`ifdef MULTDIV_DIV0_BYPASS_EN
      checks++; if (nd !== 0) begin failures++; $display("FAIL div0_pulse got=%0d exp=0", nd); end
      checks++; if (wc !== 1) begin failures++; $display("FAIL div0_wb_cycle got=%0d exp=1", wc); end
      checks++; if (sl !== 1) begin failures++; $display("FAIL div0_stall_low got=%0d exp=1", sl); end
`else
      checks++; if (nd !== 1) begin failures++; $display("FAIL div0_pulse got=%0d exp=1", nd); end
      checks++; if (wc !== 6) begin failures++; $display("FAIL div0_wb_cycle got=%0d exp=6", wc); end
`endif
      checks++; if (we !== 1'b1 || wr !== '0 || wrd !== 5'd8) begin failures++; $display("FAIL div0_result got=%h/%b/rd%0d exp=0/1/rd8", wr, we, wrd); end
   endtask

   initial begin
      test_reset();
      test_mult();
      idle_cycles(2);
      test_div();
      test_stale_ready();
      test_timeout();
      idle_cycles(1);
      test_flush();
      test_reset_mid_op();
      test_div_zero();
      idle_cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
